// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory request/response bus
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with load/clear/hold; FETCH_MISALIGN_EN adds misalign flag
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
`ifdef FETCH_MISALIGN_EN
    input  logic        load_misalign,
    output logic        ifid_misalign,
`endif
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
);

    // Clear only drops valid; the payload keeps its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_valid    <= 1'b0;
            ifid_pc       <= 32'd0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc4      <= 32'd0;
`ifdef FETCH_MISALIGN_EN
            ifid_misalign <= 1'b0;
`endif
        end else if (clear) begin
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_valid    <= 1'b1;
            ifid_pc       <= load_pc;
            ifid_instr    <= load_instr;
            ifid_pc4      <= pc_plus4(load_pc);
`ifdef FETCH_MISALIGN_EN
            ifid_misalign <= load_misalign;
`endif
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: imem handshake, stall hold buffer, flush drop; FETCH_MISALIGN_EN enables misalign trap
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    fetch_if.master     imem,
    output logic        pc_write,
    output logic [31:0] next_pc,
`ifdef FETCH_MISALIGN_EN
    output logic        ifid_misalign,
`endif
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4
);

    fetch_state_t state_q, state_d;
    logic [31:0]  hold_pc, hold_instr, drop_addr;
    logic [31:0]  fetch_addr, load_pc, load_instr;
    logic         ifid_load, ifid_clear, hold_capture, drop_capture;
`ifdef FETCH_MISALIGN_EN
    logic         load_misalign;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            hold_pc    <= 32'd0;
            hold_instr <= 32'd0;
            drop_addr  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (hold_capture) begin
                hold_pc    <= pc_in;
                hold_instr <= imem.imem_rdata;
            end
            if (drop_capture)
                drop_addr <= pc_in;
        end
    end

    always_comb begin
        state_d       = state_q;
        imem.imem_req = 1'b0;
        fetch_addr    = pc_in;
        pc_write      = 1'b0;
        next_pc       = pc_plus4(pc_in);
        ifid_load     = 1'b0;
        ifid_clear    = 1'b0;
        load_pc       = pc_in;
        load_instr    = imem.imem_rdata;
        hold_capture  = 1'b0;
        drop_capture  = 1'b0;
`ifdef FETCH_MISALIGN_EN
        load_misalign = 1'b0;
`endif
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
`ifdef FETCH_MISALIGN_EN
                    // A misaligned PC never reaches memory; it parks until redirected.
                    if (pc_in[1:0] != 2'b00) begin
                        if (flush) begin
                            pc_write   = 1'b1;
                            next_pc    = redirect_pc;
                            ifid_clear = 1'b1;
                        end else if (!stall) begin
                            ifid_load     = 1'b1;
                            load_instr    = NOP_INSTR;
                            load_misalign = 1'b1;
                        end
                    end else
`endif
                    begin
                        imem.imem_req = 1'b1;
                        if (flush) begin
                            pc_write   = 1'b1;
                            next_pc    = redirect_pc;
                            ifid_clear = 1'b1;
                            // The pending request must still complete before refetching.
                            if (!imem.imem_ready) begin
                                drop_capture = 1'b1;
                                state_d      = DROP;
                            end
                        end else if (imem.imem_ready) begin
                            if (!stall) begin
                                ifid_load = 1'b1;
                                pc_write  = 1'b1;
                            end else begin
                                hold_capture = 1'b1;
                                state_d      = HOLD;
                            end
                        end else if (!stall) begin
                            ifid_clear = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        pc_write   = 1'b1;
                        next_pc    = redirect_pc;
                        ifid_clear = 1'b1;
                        state_d    = FETCH;
                    end else if (!stall) begin
                        ifid_load  = 1'b1;
                        load_pc    = hold_pc;
                        load_instr = hold_instr;
                        pc_write   = 1'b1;
                        next_pc    = pc_plus4(hold_pc);
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    imem.imem_req = 1'b1;
                    fetch_addr    = drop_addr;
                    if (flush) begin
                        pc_write   = 1'b1;
                        next_pc    = redirect_pc;
                        ifid_clear = 1'b1;
                    end
                    if (imem.imem_ready)
                        state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_EN
    assign imem.imem_addr = fetch_addr;
`else
    assign imem.imem_addr = fetch_addr & ~32'h3;
`endif

    ifid_reg u_ifid_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (ifid_load),
        .clear         (ifid_clear),
        .load_pc       (load_pc),
        .load_instr    (load_instr),
`ifdef FETCH_MISALIGN_EN
        .load_misalign (load_misalign),
        .ifid_misalign (ifid_misalign),
`endif
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, flush, pc_write;
    logic [31:0] pc_in, redirect_pc, next_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_instr, ifid_pc4;
`ifdef FETCH_MISALIGN_EN
    logic        ifid_misalign;
`endif

    fetch_if imem ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .pc_write    (pc_write),
        .next_pc     (next_pc),
`ifdef FETCH_MISALIGN_EN
        .ifid_misalign (ifid_misalign),
`endif
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the PC register, the IF/ID contents, and what is outstanding.
    logic [31:0] m_pc;
    logic        m_holding, m_dropping;
    logic [31:0] m_held_pc, m_held_word, m_drop_addr;
    logic        m_v, m_mis;
    logic [31:0] m_ipc, m_iins, m_ipc4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_v = 1'b0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_iins = NOP_INSTR; m_mis = 1'b0;
        m_holding = 1'b0; m_dropping = 1'b0;
    endtask

    task automatic model_load(input logic [31:0] a, input logic [31:0] w, input logic mis);
        m_v = 1'b1; m_ipc = a; m_iins = w; m_ipc4 = a + 32'd4; m_mis = mis;
    endtask

    task automatic step(input bit rst, input bit st, input bit fl, input logic [31:0] rd, input bit rdy);
        logic        e_req, e_pw, misf, rv;
        logic [31:0] e_addr, e_np, w;
        @(negedge clk);
        reset = rst; stall = st; flush = fl; redirect_pc = rd; pc_in = m_pc;
        misf = 1'b0;
`ifdef FETCH_MISALIGN_EN
        misf = !m_holding && !m_dropping && (m_pc[1:0] != 2'b00);
`endif
        e_req  = !rst && !m_holding && !misf;
        e_addr = m_dropping ? m_drop_addr : m_pc;
`ifndef FETCH_MISALIGN_EN
        e_addr[1:0] = 2'b00;
`endif
        rv = rdy && e_req;
        w  = word_of(e_addr);
        imem.imem_ready = rv;
        imem.imem_rdata = w;
        e_pw = 1'b0; e_np = 32'd0;
        if (rst) ;
        else if (fl) begin e_pw = 1'b1; e_np = rd; end
        else if (m_holding) begin if (!st) begin e_pw = 1'b1; e_np = m_held_pc + 32'd4; end end
        else if (m_dropping || misf) ;
        else if (rv && !st) begin e_pw = 1'b1; e_np = m_pc + 32'd4; end
        #1;
        check("ifid_valid", ifid_valid, m_v);
        check("ifid_pc", ifid_pc, m_ipc);
        check("ifid_instr", ifid_instr, m_iins);
        check("ifid_pc4", ifid_pc4, m_ipc4);
`ifdef FETCH_MISALIGN_EN
        check("ifid_misalign", ifid_misalign, m_mis);
`endif
        check("imem_req", imem.imem_req, e_req);
        if (e_req) check("imem_addr", imem.imem_addr, e_addr);
        check("pc_write", pc_write, e_pw);
        if (e_pw) check("next_pc", next_pc, e_np);
        if (rst) model_reset();
        else begin
            if (m_holding) begin
                if (fl) begin m_v = 1'b0; m_holding = 1'b0; end
                else if (!st) begin model_load(m_held_pc, m_held_word, 1'b0); m_holding = 1'b0; end
            end else if (m_dropping) begin
                if (fl) m_v = 1'b0;
                if (rv) m_dropping = 1'b0;
            end else if (misf) begin
                if (fl) m_v = 1'b0;
                else if (!st) model_load(m_pc, NOP_INSTR, 1'b1);
            end else if (fl) begin
                m_v = 1'b0;
                if (!rv) begin m_dropping = 1'b1; m_drop_addr = m_pc; end
            end else if (rv) begin
                if (!st) model_load(m_pc, w, 1'b0);
                else begin m_holding = 1'b1; m_held_pc = m_pc; m_held_word = w; end
            end else if (!st) m_v = 1'b0;
            if (e_pw) m_pc = e_np;
        end
    endtask

    initial begin
        logic [31:0] r, rd;
        bit          rst, st, fl, rdy;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0; pc_in = 32'd0;
        imem.imem_ready = 1'b0; imem.imem_rdata = 32'd0;
        m_pc = 32'd0;
        repeat (2) @(posedge clk);
        model_reset();
        step(1, 0, 0, 0, 0);
        check("rst_instr_nop", ifid_instr, 32'h0000_0013);

        // Same-cycle response at PC 0.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("lat1_pc", ifid_pc, 32'h0);
        check("lat1_instr", ifid_instr, word_of(32'h0));

        // Response delayed three cycles at 0x8.
        step(0, 0, 1, 32'h8, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Stall when the 0x10 response arrives.
        step(0, 0, 1, 32'h10, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("hold_next_pc", next_pc, 32'h14);
        step(0, 1, 0, 0, 0);
        check("hold_ifid_pc", ifid_pc, 32'h10);

        // Flush while the 0x20 request is pending.
        step(0, 0, 1, 32'h20, 1);
        step(0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0);
        check("drop_addr", imem.imem_addr, 32'h20);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("after_drop_addr", imem.imem_addr, 32'h100);
        step(0, 0, 0, 0, 0);
        check("after_drop_ifid_pc", ifid_pc, 32'h100);

        // Flush and stall together while holding.
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'h200, 0);
        step(0, 0, 0, 0, 1);

        // PC wrap.
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_next_pc", next_pc, 32'h0);

        // Reset in the middle of a drop.
        step(0, 0, 1, 32'h300, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_drop_nop", ifid_instr, 32'h0000_0013);

`ifdef FETCH_MISALIGN_EN
        step(0, 0, 1, 32'h2, 1);
        step(0, 0, 0, 0, 1);
        check("mis_req", imem.imem_req, 1'b0);
        step(0, 0, 0, 0, 1);
        check("mis_flag", ifid_misalign, 1'b1);
        step(0, 0, 1, 32'h400, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            r   = $urandom;
            rd  = r;
            if ($urandom_range(0, 7) != 0) rd[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) rd = 32'hFFFF_FFF8 | {28'd0, rd[3:0] & 4'h4};
            step(rst, st, fl, rd, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on posedge clk.
REQ-003 SHALL have port pc_in, input, 32, current PC (driven from pc.pc_out).
REQ-004 SHALL have port stall, input, 1, hazard unit freezes IF/ID and PC.
REQ-005 SHALL have port flush, input, 1, redirect request (taken branch/jump).
REQ-006 SHALL have port redirect_pc, input, 32, target address, valid while flush=1.
REQ-007 SHALL have port imem_req, output, 1, instruction memory request.
REQ-008 SHALL have port imem_addr, output, 32, request address, stable while imem_req=1 and imem_ready=0.
REQ-009 SHALL have port imem_ready, input, 1, response strobe; imem_rdata valid the same cycle; may be high in the first req cycle.
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-011 SHALL have port pc_write, output, 1, combinational PC enable (drives pc.pc_write).
REQ-012 SHALL have port next_pc, output, 32, combinational PC next value (drives pc.next_pc).
REQ-013 SHALL have ports ifid_valid (1), ifid_pc (32), ifid_instr (32) and ifid_pc4 (32), all outputs, forming the registered IF/ID payload.

Function
REQ-014 SHALL implement states FETCH, HOLD and DROP.
REQ-015 In FETCH: imem_req=1 and imem_addr=pc_in.
REQ-016 FETCH, imem_ready=1, stall=0, flush=0: load ifid_valid=1, ifid_pc=pc_in, ifid_instr=imem_rdata, ifid_pc4=pc_in+4; pc_write=1 with next_pc=pc_in+4; remain in FETCH.
REQ-017 FETCH, imem_ready=1, stall=1, flush=0: capture pc_in and rdata into a hold buffer; pc_write=0; hold IF/ID; go to HOLD.
REQ-018 FETCH, imem_ready=0, stall=0, flush=0: ifid_valid<=0 (bubble), pc_write=0.
REQ-019 HOLD: imem_req=0; while stall=1, hold everything; when stall=0, load IF/ID from the buffer, pc_write=1 with next_pc=buffer_pc+4, then go to FETCH.
REQ-020 flush=1 in any state: pc_write=1, next_pc=redirect_pc, ifid_valid<=0; flush overrides stall.
REQ-021 Flush in FETCH with imem_ready=1: discard the response and remain in FETCH.
REQ-022 Flush in FETCH with imem_ready=0: latch drop_addr=pc_in and go to DROP.
REQ-023 Flush in HOLD: discard the buffer and go to FETCH.
REQ-024 DROP: imem_req=1, imem_addr=drop_addr; on imem_ready=1, discard the response and go to FETCH; a flush in DROP updates the PC and stays in DROP.
REQ-025 While stall=1 and flush=0, the IF/ID registers SHALL hold their values.
REQ-026 PC arithmetic SHALL be 32-bit modulo, so 0xFFFFFFFC+4 = 0x00000000.
REQ-027 Minimum latency SHALL be 1 cycle: imem_ready in the request cycle makes the result visible on IF/ID at the next posedge.

Reset
REQ-028 Reset SHALL force: state=FETCH, ifid_valid=0, ifid_pc=0, ifid_pc4=0, ifid_instr=0x00000013 (NOP), buffers cleared.
REQ-029 While reset=1: imem_req=0 and pc_write=0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request without a DROP phase.

Configuration
REQ-031 With FETCH_MISALIGN_EN defined: output ifid_misalign (1) is present.
REQ-032 Under that macro, pc_in[1:0]!=0 in FETCH SHALL give imem_req=0; IF/ID loads valid=1, misalign=1, instr=NOP; pc_write=0 until flush.
REQ-033 Without FETCH_MISALIGN_EN: no ifid_misalign port, and imem_addr[1:0] is forced to 2'b00.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, the NOP_INSTR constant (0x00000013) and PC_INCR (4).
REQ-035 The IF/ID register SHALL be a sub-module, ifid_reg, with load/clear/hold controls.

Verification
REQ-036 pc_in=0x0, ready in the same cycle, no stall: IF/ID shows pc 0x0 and instr=rdata; next_pc=0x4; pc_write=1.
REQ-037 ready delayed 3 cycles: imem_addr stays 0x8 throughout; 3 bubbles (ifid_valid=0); then instr loads.
REQ-038 stall=1 when ready arrives for 0x10: HOLD; PC stays 0x10 for 2 cycles; on release, ifid_pc=0x10 and next_pc=0x14.
REQ-039 flush to 0x100 while the 0x20 request is pending: next_pc=0x100; DROP keeps imem_addr=0x20 until ready; the 0x20 word never reaches IF/ID; the next fetch is at 0x100.
REQ-040 flush and stall together in HOLD: flush wins; buffer discarded; ifid_valid=0; next fetch at redirect_pc.
REQ-041 With FETCH_MISALIGN_EN, pc_in=0x2: imem_req=0 and ifid_misalign=1; reset mid-DROP returns to FETCH with ifid_instr=0x00000013.
